// File: rtl/param_sync_fifo.sv
// param_sync_fifo
// Single-clock FIFO with a parameterised width and depth. It has registered
// read data, almost-full and almost-empty thresholds, and sticky
// overflow/underflow flags.
// Pointers are P+1 bits wide. The low P bits address the memory, and the MSB
// tells a full FIFO apart from an empty one.

module param_sync_fifo #(
  parameter int W      = 8,
  parameter int P      = 4,
  parameter int AF_LVL = (1 << P) - 2,
  parameter int AE_LVL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] data_in,
  input  logic         rd_en,
  input  logic         clr_err,
  output logic [W-1:0] data_out,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [P:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH   = 1 << P;
  localparam logic [P:0] C_ONE   = (P+1)'(1);
  localparam logic [P:0] C_AF    = (P+1)'(AF_LVL);
  localparam logic [P:0] C_AE    = (P+1)'(AE_LVL);

  // Storage is deliberately left without a reset. Reset zeroes the pointers,
  // so a stale entry can never be presented before it has been rewritten.
  logic [W-1:0] r_mem [DEPTH];

  logic [P:0]   r_wptr;
  logic [P:0]   r_rptr;
  logic [P:0]   r_count;
  logic [W-1:0] r_dataOut;
  logic         r_overflow;
  logic         r_underflow;

  logic         w_full;
  logic         w_empty;
  logic         w_wrAccept;
  logic         w_rdAccept;
  logic         w_ovfSet;
  logic         w_unfSet;
  logic [P:0]   w_countNext;
  logic         w_ovfNext;
  logic         w_unfNext;

  // Status flags come only from registered pointers and the count, so no
  // input reaches an output combinationally.
  always_comb begin
    w_empty = 1'b0;
    w_full  = 1'b0;
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[P-1:0] == r_rptr[P-1:0]) && (r_wptr[P] != r_rptr[P]);
  end

  // Accept and reject decisions, next occupancy, and next sticky error state.
  // When the FIFO is full, a simultaneous read frees a slot, so the write is
  // accepted. When it is empty, a simultaneous read is refused, so the slot
  // being written is never read in the same cycle.
  always_comb begin
    w_wrAccept  = 1'b0;
    w_rdAccept  = 1'b0;
    w_ovfSet    = 1'b0;
    w_unfSet    = 1'b0;
    w_countNext = r_count;
    w_ovfNext   = r_overflow;
    w_unfNext   = r_underflow;

    w_wrAccept = wr_en && (!w_full || rd_en);
    w_rdAccept = rd_en && !w_empty;
    w_ovfSet   = wr_en && w_full && !rd_en;
    w_unfSet   = rd_en && w_empty;

    case ({w_wrAccept, w_rdAccept})
      2'b10:   w_countNext = r_count + C_ONE;
      2'b01:   w_countNext = r_count - C_ONE;
      default: w_countNext = r_count;
    endcase

    if (w_ovfSet) begin
      w_ovfNext = 1'b1;
    end else if (clr_err) begin
      w_ovfNext = 1'b0;
    end

    if (w_unfSet) begin
      w_unfNext = 1'b1;
    end else if (clr_err) begin
      w_unfNext = 1'b0;
    end
  end

  // Write port. A rejected write leaves the memory untouched.
  always_ff @(posedge clk) begin
    if (w_wrAccept) begin
      r_mem[r_wptr[P-1:0]] <= data_in;
    end
  end

  // Pointers, occupancy, registered read data and sticky flags. Reset aborts
  // traffic at once, independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dataOut   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAccept) begin
        r_wptr <= r_wptr + C_ONE;
      end
      if (w_rdAccept) begin
        r_rptr    <= r_rptr + C_ONE;
        r_dataOut <= r_mem[r_rptr[P-1:0]];
      end
      r_count     <= w_countNext;
      r_overflow  <= w_ovfNext;
      r_underflow <= w_unfNext;
    end
  end

  assign data_out     = r_dataOut;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo
// Directed and randomised traffic for param_sync_fifo at its default
// parameters. The reference model is a queue that holds the FIFO contents.

module tb_param_sync_fifo;

  localparam int W     = 8;
  localparam int P     = 4;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [W-1:0] data_in;
  logic         rd_en;
  logic         clr_err;
  logic [W-1:0] data_out;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [P:0]   count;
  logic         overflow;
  logic         underflow;

  int checks;
  int failures;

  logic [W-1:0] mq[$];
  logic [W-1:0] expData;
  logic         expOvf;
  logic         expUnf;

  param_sync_fifo #(.W(W), .P(P)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    chk({step, ":data_out"},     32'(data_out),     32'(expData));
    chk({step, ":count"},        32'(count),        32'(mq.size()));
    chk({step, ":full"},         32'(full),         32'(mq.size() == DEPTH));
    chk({step, ":empty"},        32'(empty),        32'(mq.size() == 0));
    chk({step, ":almost_full"},  32'(almost_full),  32'(mq.size() >= AF));
    chk({step, ":almost_empty"}, 32'(almost_empty), 32'(mq.size() <= AE));
    chk({step, ":overflow"},     32'(overflow),     32'(expOvf));
    chk({step, ":underflow"},    32'(underflow),    32'(expUnf));
  endtask

  task automatic modelReset();
    mq.delete();
    expData = '0;
    expOvf  = 1'b0;
    expUnf  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by its rules, then check
  // the DUT shortly after the rising edge.
  task automatic applyStimulus(input logic wr, input logic [W-1:0] din,
                               input logic rd, input logic clr, input string step);
    bit isFull;
    bit isEmpty;
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clr_err = clr;
    isFull  = (mq.size() == DEPTH);
    isEmpty = (mq.size() == 0);
    if (rd && !isEmpty) expData = mq.pop_front();
    if (wr && (!isFull || rd)) mq.push_back(din);
    if (wr && isFull && !rd) expOvf = 1'b1;
    else if (clr) expOvf = 1'b0;
    if (rd && isEmpty) expUnf = 1'b1;
    else if (clr) expUnf = 1'b0;
    @(posedge clk);
    #1;
    checkOutput(step);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    wr_en    = 1'b0;
    data_in  = '0;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    modelReset();

    #2;
    checkOutput("in_reset");
    @(posedge clk);
    #1;
    checkOutput("in_reset_clocked");
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("after_reset");

    // Fill with 0x00, 0x02, ... 0x1E
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, W'(2 * i), 1'b0, 1'b0, "fill");

    // A 17th write is rejected and flags overflow.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, "overflow_write");

    // Drain and verify the order. Overflow stays sticky.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");

    // Underflow on empty, then clear both flags.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "underflow_read");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clr_err");

    // Write and read together on an empty FIFO: only the write goes in.
    applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, "empty_wr_rd");
    // A new error in the same cycle as clr_err wins.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "drain_one");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, "err_beats_clr");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "clr_err2");

    // Full, then write and read together: old head comes out, 0xAA goes in.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0, "refill");
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0, "full_wr_rd");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain_aa");

    // 40 writes and 40 reads interleaved at occupancy 3..5, wrapping the pointers.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'(8'h40 + i), 1'b0, 1'b0, "prime");
    for (int i = 4; i < 40; i++) begin
      applyStimulus(1'b1, W'(8'h40 + i), 1'b0, 1'b0, "stream_wr");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "stream_rd");
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "stream_tail");

    // Randomised traffic, biased so that writes and reads are about equal.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), "random");
    end

    // Reset in the middle of a burst at count 7, away from any clock edge.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, "pre_burst_clr");
    while (mq.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "pre_burst_drain");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, W'(8'h70 + i), 1'b0, 1'b0, "burst");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "burst_rd");
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, "burst_to7");
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    checkOutput("reset_released");
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, "post_reset_wr");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "post_reset_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter W, default 8: data width in bits.
REQ-002 SHALL have parameter P, default 4: pointer bits; DEPTH = 1<<P entries.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2: almost_full threshold, legal range 1..DEPTH.
REQ-004 SHALL have parameter AE_LVL, default 2: almost_empty threshold, legal range 0..DEPTH-1.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port data_in  input  W  write data.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port data_out  output  W  registered read data.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port almost_full  output  1  count >= AF_LVL.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LVL.
REQ-016 SHALL have port count  output  P+1  current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  sticky: write rejected.
REQ-018 SHALL have port underflow  output  1  sticky: read rejected.

Function
REQ-019 SHALL store data in a DEPTH x W memory addressed by the low P bits of the P+1-bit write and read pointers.
REQ-020 SHALL accept a write when wr_en=1 and (full=0 or rd_en=1): write mem[wptr], wptr+1.
REQ-021 SHALL accept a read when rd_en=1 and empty=0: data_out <= mem[rptr] on that edge, rptr+1; read latency 1 cycle.
REQ-022 SHALL hold data_out unchanged on cycles with no accepted read.
REQ-023 SHALL wrap both pointers modulo 2^(P+1); MSB differs and low bits equal means full; all bits equal means empty.
REQ-024 SHALL update count each edge: +1 write only, -1 read only, unchanged for both or neither.
REQ-025 Full with wr_en=1 and rd_en=1: both accepted; count stays DEPTH; overflow not set.
REQ-026 Empty with wr_en=1 and rd_en=1: write accepted, read rejected; count becomes 1; underflow set.
REQ-027 SHALL set overflow when wr_en=1, full=1, rd_en=0; write discarded, memory and pointers unchanged.
REQ-028 SHALL set underflow when rd_en=1 and empty=1; pointers and data_out unchanged.
REQ-029 SHALL clear overflow/underflow on clr_err=1; a new error in the same cycle has priority, flag stays 1.
REQ-030 SHALL derive full, empty, almost_full, almost_empty combinationally from registered count/pointers only; no input-to-output combinational path.
REQ-031 SHALL never read the memory location being written in the same cycle when the FIFO is empty (REQ-026 rejects the read).

Reset
REQ-032 SHALL, while reset=0, force wptr=0, rptr=0, count=0, data_out=0, overflow=0, underflow=0, independent of clk.
REQ-033 SHALL show empty=1, full=0, almost_empty=1, almost_full=0 during and after reset.
REQ-034 SHALL abort any in-progress traffic on reset mid-operation; memory contents are don't-care and are never presented without a new write.
REQ-035 SHALL leave memory uninitialised by reset.

Verification
REQ-036 Reset, then write 0x00,0x02,...,0x1E (16 words, defaults) -> full=1 and count=16 after 16th edge; almost_full=1 from count 14.
REQ-037 From full, 17th write with rd_en=0 -> overflow=1, count=16; 16 reads return 0x00..0x1E in order, each one cycle after rd_en; empty=1 at end.
REQ-038 From empty, rd_en=1 -> underflow=1, data_out unchanged; clr_err=1 one cycle -> underflow=0.
REQ-039 Full, wr_en=rd_en=1 with data_in=0xAA -> data_out=0x00, count=16, overflow=0; 0xAA read out as 16th word after it.
REQ-040 Write 40 and read 40 words interleaved at count 3..5 -> pointers wrap twice, data in order, no flags set.
REQ-041 Assert reset=0 mid-burst at count=7, asynchronous to clk -> count=0, empty=1, data_out=0 immediately; next read after one write returns that write's data.
